// File: rtl/addsub_pkg.sv
// Shared opcodes and FSM state encoding for the shared add/subtract arbiter.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/addsub_unit.sv
// Combinational ripple-carry add/subtract: s = x + (y ^ {op}) + op.
// Overflow is the XOR of the carries into and out of the MSB.
module addsub_unit
  import addsub_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  logic             sub;
  logic [WIDTH-1:0] yb;
  logic [WIDTH:0]   c;

  assign sub  = (op == OP_SUB);
  assign yb   = y ^ {WIDTH{sub}};
  assign c[0] = sub;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign s[i]   = x[i] ^ yb[i] ^ c[i];
    assign c[i+1] = (x[i] & yb[i]) | (c[i] & (x[i] ^ yb[i]));
  end

  assign cout = c[WIDTH];
  assign ovf  = c[WIDTH] ^ c[WIDTH-1];

endmodule

// File: rtl/addsub_arbiter.sv
// Two-requester round-robin front end for one add/subtract unit; one op in flight.
// Handshake at edge T gives rsp_valid in cycle T+2; rsp_ready stalls in RESP, no accepts until consumed.
module addsub_arbiter
  import addsub_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_op,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_op,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_s,
  output logic             rsp_cout,
  output logic             rsp_ovf
);

  logic [1:0]       state;
  logic             last_grant;
  logic             op_q;
  logic             id_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic             idle;
  logic             gnt0;
  logic             gnt1;
  logic [WIDTH-1:0] s_c;
  logic             cout_c;
  logic             ovf_c;

  // On a tie the requester that did not win last time gets the grant.
  assign idle       = (state == ST_IDLE);
  assign gnt0       = idle && req0_valid && (!req1_valid || last_grant);
  assign gnt1       = idle && req1_valid && (!req0_valid || !last_grant);
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  addsub_unit #(.WIDTH(WIDTH)) u_unit (
    .op  (op_q),
    .x   (x_q),
    .y   (y_q),
    .s   (s_c),
    .cout(cout_c),
    .ovf (ovf_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      op_q       <= 1'b0;
      id_q       <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_s      <= '0;
      rsp_cout   <= 1'b0;
      rsp_ovf    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt0 || gnt1) begin
            op_q       <= gnt1 ? req1_op : req0_op;
            x_q        <= gnt1 ? req1_x  : req0_x;
            y_q        <= gnt1 ? req1_y  : req0_y;
            id_q       <= gnt1;
            last_grant <= gnt1;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_valid <= 1'b1;
          rsp_id    <= id_q;
          rsp_s     <= s_c;
          rsp_cout  <= cout_c;
          rsp_ovf   <= ovf_c;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter: vector table plus arbitration, backpressure and reset sequences.
module tb_addsub_arbiter;
  import addsub_pkg::*;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req0_op;
  logic [W-1:0] req0_x, req0_y;
  logic         req1_valid, req1_ready, req1_op;
  logic [W-1:0] req1_x, req1_y;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_ovf;
  logic [W-1:0] rsp_s;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic         id;
    logic         op;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[8];

  addsub_arbiter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_op   (req0_op),
    .req0_x    (req0_x),
    .req0_y    (req0_y),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_op   (req1_op),
    .req1_x    (req1_x),
    .req1_y    (req1_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_s     (rsp_s),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic rdy_of(input logic id);
    return id ? req1_ready : req0_ready;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drive(input logic id, input logic op, input logic [W-1:0] x, input logic [W-1:0] y);
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_x = x; req1_y = y;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_x = x; req0_y = y;
    end
  endtask

  // Returns at the negedge of the handshake cycle.
  task automatic wait_rdy(input logic id, input string nm);
    int n = 0;
    @(negedge clk);
    while (!rdy_of(id) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(nm, rdy_of(id), 1);
  endtask

  task automatic run_vec(input int i);
    vec_t v = vecs[i];
    @(posedge clk); #1;
    drive(v.id, v.op, v.x, v.y);
    wait_rdy(v.id, $sformatf("v%0d_grant", i));
    check($sformatf("v%0d_other_rdy", i), rdy_of(!v.id), 0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_early_valid", i), rsp_valid, 0);
    @(negedge clk);
    check($sformatf("v%0d_valid", i), rsp_valid, 1);
    check($sformatf("v%0d_id", i), rsp_id, v.id);
    check($sformatf("v%0d_s", i), rsp_s, v.s);
    check($sformatf("v%0d_cout", i), rsp_cout, v.cout);
    check($sformatf("v%0d_ovf", i), rsp_ovf, v.ovf);
    @(posedge clk);
  endtask

  initial begin
    int grants, rsps, cyc, last_cyc;
    logic exp_gid, exp_rid, seen;

    vecs[0] = '{1'b0, OP_ADD, 5'd7,  5'd5,  5'b01100, 1'b0, 1'b0};
    vecs[1] = '{1'b1, OP_SUB, 5'd3,  5'd5,  5'b11110, 1'b0, 1'b0};
    vecs[2] = '{1'b1, OP_SUB, 5'd5,  5'd3,  5'b00010, 1'b1, 1'b0};
    vecs[3] = '{1'b0, OP_ADD, 5'd15, 5'd1,  5'b10000, 1'b0, 1'b1};
    vecs[4] = '{1'b0, OP_ADD, 5'd16, 5'd16, 5'b00000, 1'b1, 1'b1};
    vecs[5] = '{1'b1, OP_ADD, 5'd31, 5'd1,  5'b00000, 1'b1, 1'b0};
    vecs[6] = '{1'b0, OP_SUB, 5'd16, 5'd1,  5'b01111, 1'b1, 1'b1};
    vecs[7] = '{1'b1, OP_SUB, 5'd0,  5'd0,  5'b00000, 1'b1, 1'b0};

    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_op = 1'b0; req0_x = '0; req0_y = '0;
    req1_valid = 1'b0; req1_op = 1'b0; req1_x = '0; req1_y = '0;
    do_reset();

    @(negedge clk);
    check("rst_valid", rsp_valid, 0);
    check("rst_id", rsp_id, 0);
    check("rst_s", rsp_s, 0);
    check("rst_cout", rsp_cout, 0);
    check("rst_ovf", rsp_ovf, 0);
    check("rst_rdy0", req0_ready, 0);
    check("rst_rdy1", req1_ready, 0);

    for (int i = 0; i < 8; i++) run_vec(i);

    // Both requesters valid continuously from reset.
    do_reset();
    drive(1'b0, OP_ADD, 5'd1, 5'd2);
    drive(1'b1, OP_SUB, 5'd9, 5'd4);
    grants = 0; rsps = 0; cyc = 0; last_cyc = 0;
    exp_gid = 1'b0; exp_rid = 1'b0;
    while ((grants < 4 || rsps < 4) && cyc < 40) begin
      @(negedge clk);
      cyc++;
      check("tie_both_ready", {31'd0, req0_ready & req1_ready}, 0);
      if (grants < 4 && (req0_ready || req1_ready)) begin
        check("tie_grant_id", req1_ready, exp_gid);
        if (grants > 0) check("tie_grant_gap", cyc - last_cyc, 3);
        last_cyc = cyc;
        exp_gid = ~exp_gid;
        grants++;
      end
      if (rsps < 4 && rsp_valid) begin
        check("tie_rsp_id", rsp_id, exp_rid);
        check("tie_rsp_s", rsp_s, exp_rid ? 5'd5 : 5'd3);
        exp_rid = ~exp_rid;
        rsps++;
      end
    end
    check("tie_done", (grants >= 4 && rsps >= 4), 1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (6) @(posedge clk);

    // Response backpressure with a competing request pending.
    #1 rsp_ready = 1'b0;
    drive(1'b0, OP_ADD, 5'd7, 5'd5);
    wait_rdy(1'b0, "bp_grant");
    @(posedge clk); #1;
    req0_valid = 1'b0;
    drive(1'b1, OP_SUB, 5'd3, 5'd5);
    @(negedge clk);
    check("bp_exec_rdy1", req1_ready, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d_valid", k), rsp_valid, 1);
      check($sformatf("bp_hold%0d_s", k), rsp_s, 5'd12);
      check($sformatf("bp_hold%0d_id", k), rsp_id, 0);
      check($sformatf("bp_hold%0d_rdy", k), {req0_ready, req1_ready}, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_consume_rdy1", req1_ready, 0);
    @(negedge clk);
    check("bp_after_valid", rsp_valid, 0);
    check("bp_resume_rdy1", req1_ready, 1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("bp_next_id", rsp_id, 1);
    check("bp_next_s", rsp_s, 5'b11110);
    repeat (3) @(posedge clk);

    // Reset while an operation is in EXEC.
    #1 drive(1'b0, OP_ADD, 5'd7, 5'd5);
    wait_rdy(1'b0, "rx_grant");
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rx_valid", rsp_valid, 0);
    check("rx_id", rsp_id, 0);
    check("rx_s", rsp_s, 0);
    check("rx_cout", rsp_cout, 0);
    check("rx_ovf", rsp_ovf, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("rx_no_rsp", seen, 0);
    @(posedge clk); #1;
    drive(1'b0, OP_ADD, 5'd1, 5'd1);
    drive(1'b1, OP_ADD, 5'd2, 5'd2);
    @(negedge clk);
    check("rx_tie_rdy0", req0_ready, 1);
    check("rx_tie_rdy1", req1_ready, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
